uart_tx_gen: RTL and testbench

Parametrised, single-clock UART transmitter: the next generation of the UART TX path. Bytes from the host clock domain enter an internal synchronous FIFO. A runtime-configurable serialiser then shifts them out with selectable data length, parity and stop bits. Bit timing comes from an internal baud divider. The block adds CTS/RTS flow control, break generation and a FIFO fill level, and sits between the UART register block and the TX pin.

---
 rtl/uart_defs.sv | 34 +++
 rtl/fifo_sync.sv | 61 ++++++
 rtl/uart_tx_gen.sv | 189 ++++++++++++++++++
 tb/tb_uart_tx_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions used by the TX generator and the future RX path.
// Holds parity modes, TX FSM states and a parity helper.
package uart_defs;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'd0,
        PAR_EVEN     = 2'd1,
        PAR_ODD      = 2'd2,
        PAR_NONE_ALT = 2'd3
    } Parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } TxGenState_t;

    localparam int UART_MIN_DATA_BITS = 5;

    // XOR of the lowest n bits of d.
    function automatic logic even_parity(input logic [15:0] d,
                                         input logic [3:0]  n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(n)) p ^= d[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO with flush and occupancy level.
// Flush wins over any same-cycle write or read.
module fifo_sync #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_en,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_rd_en,
    output logic [DATA_W-1:0]          o_rd_data,
    input  logic                       i_flush,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [LW-1:0]     r_level;
    logic              w_wr;
    logic              w_rd;

    assign w_wr = i_wr_en && !o_full && !i_flush;
    assign w_rd = i_rd_en && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rptr];
    assign o_level   = r_level;
    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter: FIFO, CTS/RTS flow control, configurable framing and break.
// tx_o is registered from the next state so it changes on the deciding edge.
module uart_tx_gen
    import uart_defs::*;
#(
    parameter int DATA_W     = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               data_i,
    input  logic                            data_valid_i,
    output logic                            data_ready_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
    input  logic                            flush_i,
    input  logic                            enable_i,
    input  logic [3:0]                      data_bits_i,
    input  logic [1:0]                      parity_i,
    input  logic                            stop2_i,
    input  logic [DIV_W-1:0]                baud_div_i,
    input  logic                            break_i,
    input  logic                            cts_n_i,
    output logic                            rts_n_o,
    output logic                            tx_o,
    output logic                            busy_o,
    output logic                            done_o
);

    TxGenState_t       r_state;
    TxGenState_t       w_state_d;
    logic              r_cts_meta;
    logic              r_cts_sync;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_baud_cnt;
    logic [3:0]        r_nbits;
    logic [3:0]        r_bit_idx;
    logic [3:0]        w_nbits;
    Parity_t           r_par;
    logic              r_stop2;
    logic              r_par_bit;
    logic              r_brk_mark;
    logic              r_tx;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_d;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_bit_end;
    logic              w_last_data;
    logic              w_last_stop;
    logic              w_frame_end;
    logic              w_start_ok;
    logic              w_par_on;
    logic              w_pop;
    logic              w_tx_d;

    fifo_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (data_valid_i),
        .i_wr_data (data_i),
        .i_rd_en   (w_pop),
        .o_rd_data (w_fifo_data),
        .i_flush   (flush_i),
        .o_level   (level_o),
        .o_full    (full_o),
        .o_empty   (empty_o)
    );

    assign data_ready_o = !full_o;

    assign w_nbits = (data_bits_i < 4'(UART_MIN_DATA_BITS) ||
                      data_bits_i > 4'(DATA_W)) ? 4'(DATA_W) : data_bits_i;

    assign w_bit_end   = (r_baud_cnt == r_div);
    assign w_last_data = (r_bit_idx == r_nbits - 4'd1);
    assign w_last_stop = (r_bit_idx == {3'b000, r_stop2});
    assign w_frame_end = (r_state == STOP) && w_bit_end && w_last_stop;
    assign w_start_ok  = enable_i && !empty_o && !r_cts_sync;
    assign w_par_on    = (r_par == PAR_EVEN) || (r_par == PAR_ODD);
    assign w_pop       = (w_state_d == START) && (r_state != START);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_d;
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            IDLE: begin
                if (break_i)         w_state_d = BREAK;
                else if (w_start_ok) w_state_d = START;
            end
            START:  if (w_bit_end) w_state_d = DATA;
            DATA: begin
                if (w_bit_end && w_last_data)
                    w_state_d = w_par_on ? PARITY : STOP;
            end
            PARITY: if (w_bit_end) w_state_d = STOP;
            STOP: begin
                if (w_frame_end)
                    w_state_d = (w_start_ok && !break_i) ? START : IDLE;
            end
            BREAK:  if (r_brk_mark && w_bit_end) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_shift_d = r_shift;
        if (w_pop)
            w_shift_d = w_fifo_data;
        else if (r_state == DATA && w_bit_end)
            w_shift_d = r_shift >> 1;
    end

    // Line level for the cycle that follows this edge.
    always_comb begin
        w_tx_d = 1'b1;
        unique case (w_state_d)
            START:   w_tx_d = 1'b0;
            DATA:    w_tx_d = w_shift_d[0];
            PARITY:  w_tx_d = r_par_bit;
            BREAK:   w_tx_d = r_brk_mark || !break_i;
            default: w_tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cts_meta <= 1'b1;
            r_cts_sync <= 1'b1;
            r_tx       <= 1'b1;
            r_shift    <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_brk_mark <= 1'b0;
            r_div      <= '0;
            r_nbits    <= 4'(DATA_W);
            r_par      <= PAR_NONE;
            r_stop2    <= 1'b0;
            r_par_bit  <= 1'b0;
        end else begin
            r_cts_meta <= cts_n_i;
            r_cts_sync <= r_cts_meta;
            r_tx       <= w_tx_d;
            r_shift    <= w_shift_d;

            if (w_state_d != r_state || w_bit_end || r_state == IDLE ||
                (r_state == BREAK && !r_brk_mark))
                r_baud_cnt <= '0;
            else
                r_baud_cnt <= r_baud_cnt + 1'b1;

            if (w_state_d != r_state)
                r_bit_idx <= '0;
            else if (w_bit_end && (r_state == DATA || r_state == STOP))
                r_bit_idx <= r_bit_idx + 4'd1;

            if (r_state == BREAK) begin
                if (!break_i) r_brk_mark <= 1'b1;
            end else begin
                r_brk_mark <= 1'b0;
            end

            if (w_pop) begin
                r_div     <= baud_div_i;
                r_nbits   <= w_nbits;
                r_par     <= Parity_t'(parity_i);
                r_stop2   <= stop2_i;
                r_par_bit <= even_parity(16'(w_fifo_data), w_nbits) ^
                             (parity_i == PAR_ODD);
            end else if (r_state == IDLE && w_state_d == BREAK) begin
                r_div <= baud_div_i;
            end
        end
    end

    assign tx_o    = r_tx;
    assign busy_o  = (r_state != IDLE);
    assign done_o  = w_frame_end;
    assign rts_n_o = !(enable_i && (!empty_o || busy_o));

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed self-checking bench for uart_tx_gen.
// Frames are checked cycle by cycle against hand-computed bit sequences.
module tb_uart_tx_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [8:0]  data_i;
    logic        data_valid_i;
    logic        data_ready_o;
    logic        full_o;
    logic        empty_o;
    logic [3:0]  level_o;
    logic        flush_i;
    logic        enable_i;
    logic [3:0]  data_bits_i;
    logic [1:0]  parity_i;
    logic        stop2_i;
    logic [15:0] baud_div_i;
    logic        break_i;
    logic        cts_n_i;
    logic        rts_n_o;
    logic        tx_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_err = 0;
    int waited;
    logic quiet;

    always #5 clk = ~clk;

    uart_tx_gen dut (
        .clk          (clk),
        .rst          (rst),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_ready_o (data_ready_o),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .level_o      (level_o),
        .flush_i      (flush_i),
        .enable_i     (enable_i),
        .data_bits_i  (data_bits_i),
        .parity_i     (parity_i),
        .stop2_i      (stop2_i),
        .baud_div_i   (baud_div_i),
        .break_i      (break_i),
        .cts_n_i      (cts_n_i),
        .rts_n_o      (rts_n_o),
        .tx_o         (tx_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [8:0] d);
        data_i       = d;
        data_valid_i = 1'b1;
        @(negedge clk);
        data_valid_i = 1'b0;
    endtask

    // par: -1 = no parity bit, otherwise the expected parity bit value.
    task automatic expect_frame(input logic [8:0] d, input int n,
                                input int par, input int nstop,
                                input int div, input string tag,
                                output int wcnt);
        logic bits [16];
        int   nb;
        int   total;
        bits[0] = 1'b0;
        for (int i = 0; i < n; i++) bits[1+i] = d[i];
        nb = 1 + n;
        if (par >= 0) begin
            bits[nb] = (par != 0);
            nb++;
        end
        for (int i = 0; i < nstop; i++) begin
            bits[nb] = 1'b1;
            nb++;
        end
        wcnt = 0;
        while (tx_o !== 1'b0 && wcnt < 200) begin
            @(negedge clk);
            wcnt++;
        end
        chk({tag, "_start"}, 32'(tx_o), 32'd0);
        total = nb * (div + 1);
        for (int c = 0; c < total; c++) begin
            chk($sformatf("%s_tx_c%0d", tag, c), 32'(tx_o),
                32'(bits[c / (div + 1)]));
            chk($sformatf("%s_done_c%0d", tag, c), 32'(done_o),
                32'(c == total - 1));
            @(negedge clk);
        end
    endtask

    initial begin
        rst          = 1'b1;
        data_i       = '0;
        data_valid_i = 1'b0;
        flush_i      = 1'b0;
        enable_i     = 1'b0;
        data_bits_i  = 4'd8;
        parity_i     = 2'd0;
        stop2_i      = 1'b0;
        baud_div_i   = 16'd3;
        break_i      = 1'b0;
        cts_n_i      = 1'b1;

        @(negedge clk);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_rts", 32'(rts_n_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_ready", 32'(data_ready_o), 32'd1);
        rst      = 1'b0;
        enable_i = 1'b1;
        cts_n_i  = 1'b0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5, baud_div 3, plus write-to-start latency
        data_i       = 9'h0A5;
        data_valid_i = 1'b1;
        @(negedge clk);
        data_valid_i = 1'b0;
        chk("lat_empty", 32'(empty_o), 32'd0);
        chk("lat_level", 32'(level_o), 32'd1);
        chk("lat_tx_hi", 32'(tx_o), 32'd1);
        @(negedge clk);
        chk("lat_tx_lo", 32'(tx_o), 32'd0);
        chk("lat_busy", 32'(busy_o), 32'd1);
        chk("lat_pop", 32'(level_o), 32'd0);
        expect_frame(9'h0A5, 8, -1, 1, 3, "a5", waited);
        chk("a5_wait", 32'(waited), 32'd0);
        chk("a5_idle", 32'(busy_o), 32'd0);

        // 7-bit even/odd parity; bit 7 of 0xC1 is outside the frame
        data_bits_i = 4'd7;
        parity_i    = 2'd1;
        push(9'h0C1);
        expect_frame(9'h0C1, 7, 0, 1, 3, "e41", waited);
        push(9'h043);
        expect_frame(9'h043, 7, 1, 1, 3, "e43", waited);
        parity_i = 2'd2;
        push(9'h041);
        expect_frame(9'h041, 7, 1, 1, 3, "o41", waited);
        stop2_i = 1'b1;
        push(9'h043);
        expect_frame(9'h043, 7, 0, 2, 3, "o43s2", waited);

        // FIFO fill with CTS held off, overflow drop, flush
        data_bits_i = 4'd8;
        parity_i    = 2'd0;
        stop2_i     = 1'b0;
        cts_n_i     = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) push(9'(9'h011 + i));
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_level", 32'(level_o), 32'd8);
        chk("fill_ready", 32'(data_ready_o), 32'd0);
        push(9'h019);
        chk("ovf_level", 32'(level_o), 32'd8);
        chk("ovf_tx", 32'(tx_o), 32'd1);
        chk("ovf_busy", 32'(busy_o), 32'd0);
        chk("ovf_rts", 32'(rts_n_o), 32'd0);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        chk("flush_level", 32'(level_o), 32'd0);
        chk("flush_empty", 32'(empty_o), 32'd1);
        chk("flush_full", 32'(full_o), 32'd0);
        chk("flush_rts", 32'(rts_n_o), 32'd1);
        data_i       = 9'h0AA;
        data_valid_i = 1'b1;
        flush_i      = 1'b1;
        @(negedge clk);
        data_valid_i = 1'b0;
        flush_i      = 1'b0;
        chk("flush_wr_drop", 32'(level_o), 32'd0);

        // CTS gating: start latency, mid-frame deassert
        push(9'h05A);
        push(9'h03C);
        repeat (5) @(negedge clk);
        chk("cts_hold_tx", 32'(tx_o), 32'd1);
        chk("cts_hold_lvl", 32'(level_o), 32'd2);
        cts_n_i = 1'b0;
        waited  = 0;
        while (tx_o !== 1'b0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("cts_latency_le3", 32'(waited <= 3), 32'd1);
        fork
            begin
                repeat (12) @(negedge clk);
                cts_n_i = 1'b1;
            end
        join_none
        expect_frame(9'h05A, 8, -1, 1, 3, "c5a", waited);
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (tx_o !== 1'b1 || busy_o !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        chk("cts_withheld", 32'(quiet), 32'd1);
        chk("cts_wh_level", 32'(level_o), 32'd1);
        chk("cts_wh_rts", 32'(rts_n_o), 32'd0);
        cts_n_i = 1'b0;
        expect_frame(9'h03C, 8, -1, 1, 3, "c3c", waited);

        // baud_div 0, back-to-back frames with no idle gap
        cts_n_i    = 1'b1;
        baud_div_i = 16'd0;
        repeat (3) @(negedge clk);
        push(9'h055);
        push(9'h0F0);
        cts_n_i = 1'b0;
        expect_frame(9'h055, 8, -1, 1, 0, "b55", waited);
        expect_frame(9'h0F0, 8, -1, 1, 0, "bf0", waited);
        chk("b2b_gap", 32'(waited), 32'd0);
        chk("b2b_idle", 32'(busy_o), 32'd0);

        // break for 50 cycles, then one mark bit time
        baud_div_i = 16'd3;
        break_i    = 1'b1;
        quiet      = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b0 || busy_o !== 1'b1 || done_o !== 1'b0)
                quiet = 1'b0;
        end
        chk("brk_low50", 32'(quiet), 32'd1);
        break_i = 1'b0;
        quiet   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx_o !== 1'b1 || busy_o !== 1'b1 || done_o !== 1'b0)
                quiet = 1'b0;
        end
        chk("brk_mark", 32'(quiet), 32'd1);
        @(negedge clk);
        chk("brk_end_busy", 32'(busy_o), 32'd0);
        chk("brk_end_tx", 32'(tx_o), 32'd1);

        // asynchronous reset in the middle of a frame
        push(9'h000);
        push(9'h07E);
        waited = 0;
        while (tx_o !== 1'b0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("mid_started", 32'(tx_o), 32'd0);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", 32'(tx_o), 32'd1);
        chk("mid_rst_empty", 32'(empty_o), 32'd1);
        chk("mid_rst_level", 32'(level_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_tx", 32'(tx_o), 32'd1);
        chk("post_rst_busy", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
